// File: rtl/simprisc_wb_arbiter.sv
// Round-robin write-back arbiter for the simprisc register file write port, with a
// registered write stage and pause/drain control. Define SIMPRISC_WB_FWD_EN for the forwarding port.
module simprisc_wb_arbiter #(
    parameter int XLEN    = 32,
    parameter int N_REQ   = 3,
    parameter int RADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*RADDR_W-1:0] req_rd,
    input  logic [N_REQ*XLEN-1:0]    req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     pause_req,
    output logic                     paused,
    output logic                     rf_we,
    output logic [RADDR_W-1:0]       rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic [15:0]              x0_drop_cnt
`ifdef SIMPRISC_WB_FWD_EN
    ,
    input  logic [RADDR_W-1:0]       fwd_raddr,
    output logic                     fwd_hit,
    output logic [XLEN-1:0]          fwd_data
`endif
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] PAUSED = 2'd2;

    logic [1:0]         state;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      cand;
    logic               gnt_any;
    logic [RADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]    sel_data;

    logic [RADDR_W-1:0] rd_arr   [N_REQ];
    logic [XLEN-1:0]    data_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign rd_arr[i]   = req_rd[i*RADDR_W +: RADDR_W];
        assign data_arr[i] = req_data[i*XLEN +: XLEN];
    end

    // Rotating search from rr_ptr; pause_req gates the grant in the very cycle it is seen.
    always_comb begin
        int idx;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        req_ready = '0;
        idx       = 0;
        if (!rst && state == RUN && !pause_req) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N_REQ) idx = idx - N_REQ;
                cand = PW'(idx);
                if (!gnt_any && req_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
            if (gnt_any) req_ready[gnt_idx] = 1'b1;
        end
    end

    assign sel_rd   = rd_arr[gnt_idx];
    assign sel_data = data_arr[gnt_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            rr_ptr      <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            x0_drop_cnt <= '0;
        end else begin
            // Writes to x0 are accepted but never reach the register file.
            rf_we <= gnt_any && (sel_rd != '0);
            if (gnt_any) begin
                rf_waddr <= sel_rd;
                rf_wdata <= sel_data;
                rr_ptr   <= (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
                if (sel_rd == '0 && x0_drop_cnt != 16'hFFFF)
                    x0_drop_cnt <= x0_drop_cnt + 16'd1;
            end
            case (state)
                RUN:     if (pause_req) state <= DRAIN;
                DRAIN:   state <= pause_req ? PAUSED : RUN;
                PAUSED:  if (!pause_req) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign paused = (state == PAUSED);

`ifdef SIMPRISC_WB_FWD_EN
    assign fwd_hit  = rf_we && (rf_waddr == fwd_raddr) && (fwd_raddr != '0);
    assign fwd_data = fwd_hit ? rf_wdata : '0;
`endif

endmodule

// File: tb/tb_simprisc_wb_arbiter.sv
// Scoreboard bench for simprisc_wb_arbiter: a behavioural model predicts grants and
// register file writes; a negedge monitor pops expected writes and compares.
module tb_simprisc_wb_arbiter;
    localparam int N  = 3;
    localparam int XL = 32;
    localparam int AW = 5;
    localparam int M_RUN = 0, M_DRAIN = 1, M_PAUSED = 2;

    typedef struct {
        logic          we;
        logic [AW-1:0] rd;
        logic [XL-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            pause_req = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_rd = '0;
    logic [N*XL-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            paused;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XL-1:0]   rf_wdata;
    logic [15:0]     x0_drop_cnt;
`ifdef SIMPRISC_WB_FWD_EN
    logic [AW-1:0]   fwd_raddr = '0;
    logic            fwd_hit;
    logic [XL-1:0]   fwd_data;
`endif

    int tests = 0, fails = 0;
    wr_t exp_q[$];
    int m_mode = M_RUN, m_rr = 0, m_cnt = 0;
    logic [N-1:0]    ready_s = '0, p_valid = '0, p_ready = '0;
    logic [N*AW-1:0] p_rd = '0;
    logic [N*XL-1:0] p_data = '0;

    simprisc_wb_arbiter #(.XLEN(XL), .N_REQ(N), .RADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
        .req_ready(req_ready), .pause_req(pause_req), .paused(paused), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .x0_drop_cnt(x0_drop_cnt)
`ifdef SIMPRISC_WB_FWD_EN
        , .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first valid requester in rotation order starting at m_rr.
    function automatic int model_grant();
        if (rst || m_mode != M_RUN || pause_req) return -1;
        for (int k = 0; k < N; k++) begin
            int i = (m_rr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        wr_t e;
        e.we = 1'b0; e.rd = '0; e.data = '0;
        if (rst) begin
            m_mode = M_RUN; m_rr = 0; m_cnt = 0;
        end else begin
            g = model_grant();
            if (g >= 0) begin
                e.rd   = req_rd[g*AW +: AW];
                e.data = req_data[g*XL +: XL];
                e.we   = (e.rd != 0);
                if (e.rd == 0 && m_cnt < 65535) m_cnt++;
                m_rr = (g + 1) % N;
            end
            case (m_mode)
                M_RUN:   if (pause_req) m_mode = M_DRAIN;
                M_DRAIN: m_mode = pause_req ? M_PAUSED : M_RUN;
                default: if (!pause_req) m_mode = M_RUN;
            endcase
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        int g;
        wr_t e;
        g = model_grant();
        chk("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("paused", paused, m_mode == M_PAUSED);
        chk("x0_drop_cnt", x0_drop_cnt, m_cnt);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_we", rf_we, e.we);
            if (e.we) begin
                chk("rf_waddr", rf_waddr, e.rd);
                chk("rf_wdata", rf_wdata, e.data);
            end
`ifdef SIMPRISC_WB_FWD_EN
            chk("fwd_hit", fwd_hit, e.we && e.rd == fwd_raddr && fwd_raddr != 0);
            chk("fwd_data", fwd_data, (e.we && e.rd == fwd_raddr && fwd_raddr != 0) ? e.data : '0);
`endif
        end
        for (int i = 0; i < N; i++) begin
            if (p_valid[i] && !p_ready[i]) begin
                chk("hold_valid", req_valid[i], 1'b1);
                chk("hold_rd", req_rd[i*AW +: AW], p_rd[i*AW +: AW]);
                chk("hold_data", req_data[i*XL +: XL], p_data[i*XL +: XL]);
            end
        end
        p_valid = req_valid; p_ready = req_ready; p_rd = req_rd; p_data = req_data;
        ready_s = req_ready;
    end

    task automatic step();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~ready_s;
`ifdef SIMPRISC_WB_FWD_EN
        fwd_raddr = AW'($urandom_range(0, 9));
`endif
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [XL-1:0] d);
        if (!req_valid[i]) begin
            req_valid[i] = 1'b1;
            req_rd[i*AW +: AW] = rd;
            req_data[i*XL +: XL] = d;
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 20 && req_valid != 0; n++) step();
        chk("idle_timeout", req_valid, 0);
    endtask

    task automatic next_grant(output logic [N-1:0] g);
        g = '0;
        for (int n = 0; n < 6 && g == 0; n++) begin
            @(negedge clk);
            g = req_ready;
            step();
        end
    endtask

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] gseq[$];
        logic [N-1:0] want[6];
        want = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_we", rf_we, 1'b0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_paused", paused, 1'b0);

        // Single requester 1 after reset
        step();
        set_req(1, 5, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_ready", req_ready, 3'b010);
        step();
        @(negedge clk);
        chk("t1_we", rf_we, 1'b1);
        chk("t1_waddr", rf_waddr, 5);
        chk("t1_wdata", rf_wdata, 32'hDEADBEEF);

        // Reset to rr_ptr=0, then all three held valid
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            set_req(0, 1, $urandom);
            set_req(1, 2, $urandom);
            set_req(2, 3, $urandom);
            @(negedge clk);
            gseq.push_back(req_ready);
            step();
        end
        for (int c = 0; c < 6; c++) chk("t2_grant_seq", gseq[c], want[c]);
        wait_idle();

        // x0 write from requester 2
        step();
        set_req(2, 0, 32'h1234);
        @(negedge clk);
        chk("t3_ready", req_ready, 3'b100);
        step();
        @(negedge clk);
        chk("t3_we", rf_we, 1'b0);
        chk("t3_x0cnt", x0_drop_cnt, 1);

        // Move rr_ptr to 2, then pause with 0 and 2 valid
        step();
        set_req(1, 4, $urandom);
        step();
        set_req(0, 10, $urandom);
        set_req(2, 11, $urandom);
        pause_req = 1'b1;
        @(negedge clk);
        chk("t4_no_grant", req_ready, 0);
        step();
        @(negedge clk);
        chk("t4_drain_paused", paused, 1'b0);
        step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t4_paused", paused, 1'b1);
            chk("t4_paused_we", rf_we, 1'b0);
            step();
        end
        pause_req = 1'b0;
        next_grant(g);
        chk("t4_resume_first", g, 3'b100);
        next_grant(g);
        chk("t4_resume_second", g, 3'b001);
        wait_idle();

        // Reset the cycle after a transfer to rd=7
        set_req(0, 7, $urandom);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_we", rf_we, 1'b0);
        chk("t5_waddr", rf_waddr, 0);
        chk("t5_wdata", rf_wdata, 0);
        chk("t5_x0cnt", x0_drop_cnt, 0);
        step();
        set_req(2, 12, $urandom);
        set_req(0, 13, $urandom);
        next_grant(g);
        chk("t5_first_grant", g, 3'b001);
        wait_idle();

`ifdef SIMPRISC_WB_FWD_EN
        set_req(0, 9, 32'hA5A5A5A5);
        step();
        fwd_raddr = 9;
        @(negedge clk);
        chk("t6_fwd_hit", fwd_hit, 1'b1);
        chk("t6_fwd_data", fwd_data, 32'hA5A5A5A5);
        #1 fwd_raddr = 0;
        #1 chk("t6_fwd_x0", fwd_hit, 1'b0);
        step();
`endif

        // Randomized traffic with occasional pause and reset
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 2) == 0) set_req(i, AW'($urandom_range(0, 9)), $urandom);
            if ($urandom_range(0, 9) == 0) pause_req = ~pause_req;
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        pause_req = 1'b0;
        step();
        wait_idle();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/simprisc_wb_arbiter.md
Name: simprisc_wb_arbiter

Overview:
- Write-back arbiter and sequencer for the simprisc register file write port.
- Shares the single register file write port between N_REQ producers: ALU, load unit, and the regwriter/debug preload port.
- One grant per cycle, round-robin, with a registered output stage.
- Pause/drain control lets the environment quiesce write-back before inspecting or preloading registers.

Parameters:
- XLEN, 32, data width of each write.
- N_REQ, 3, number of requesters; index 0 = ALU, 1 = load, 2 = regwriter.
- RADDR_W, 5, register address width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester write request.
- req_rd  in  N_REQ*RADDR_W  flattened destination registers; requester i at bits [i*RADDR_W +: RADDR_W].
- req_data  in  N_REQ*XLEN  flattened write data; same packing.
- req_ready  out  N_REQ  one-hot grant; a transfer occurs when valid&ready.
- pause_req  in  1  level; request quiesce.
- paused  out  1  high while in PAUSED.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  RADDR_W  register file write address (registered).
- rf_wdata  out  XLEN  register file write data (registered).
- x0_drop_cnt  out  16  count of accepted writes to x0, saturating.

Behaviour:
- Reset:
  - state=RUN; rr_ptr=0.
  - req_ready=0; rf_we=0; rf_waddr=0; rf_wdata=0.
  - paused=0; x0_drop_cnt=0.
  - Reset mid-operation discards the in-flight output stage: no write issues in the cycle after rst.
- req_ready:
  - Combinational from req_valid, rr_ptr and state.
  - Zero outside RUN.
  - At most one bit set, only on a valid requester.
- Arbitration:
  - Search starts at rr_ptr, ascending, wrapping N_REQ-1 -> 0.
  - First valid requester is granted.
  - After a grant to g: rr_ptr <= (g+1) mod N_REQ.
  - No grant: rr_ptr holds.
- Latency:
  - A transfer in cycle T drives rf_we/rf_waddr/rf_wdata in cycle T+1.
  - rf_we is high exactly one cycle per transfer.
  - Back-to-back transfers give a continuous rf_we.
- x0 handling:
  - A transfer with rd==0 is accepted (ready asserted), but rf_we=0 in T+1.
  - x0_drop_cnt increments, saturating at 16'hFFFF.
- Ordering: granted writes reach the register file in grant order, so same-rd writes resolve last-granted-wins.
- Requester rules:
  - Once asserted, req_valid, req_rd and req_data hold stable until accepted.
  - The arbiter does not check this; the bench asserts it.
- State machine:
  - RUN: normal granting. pause_req=1 -> DRAIN, and no grant is issued in the cycle pause_req is first seen high.
  - DRAIN: no grants. Lasts one cycle, letting the output stage retire. Next state is PAUSED if pause_req=1, else RUN.
  - PAUSED: paused=1; no grants; rf_we=0. pause_req=0 -> RUN, with grants resuming the following cycle.
- Simultaneous events: pause_req rising while several requesters are valid means no grant that cycle. rr_ptr is unchanged, so priority is preserved across the pause.
- N_REQ=1 is legal: degenerate, always grants requester 0.

Optional Feature:
- SIMPRISC_WB_FWD_EN defined adds three ports:
  - fwd_raddr in RADDR_W;
  - fwd_hit out 1;
  - fwd_data out XLEN.
- Forwarding behaviour:
  - fwd_hit = rf_we && (rf_waddr==fwd_raddr) && (fwd_raddr!=0), combinational.
  - fwd_data = rf_wdata when fwd_hit, else 0.
- Undefined: the three ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, only requester 1 valid with rd=5, data=32'hDEADBEEF:
  - req_ready=3'b010 in the first cycle;
  - next cycle rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF;
  - rr_ptr=2.
- All three requesters held valid with distinct rd 1/2/3 for 6 cycles from rr_ptr=0:
  - grant sequence 0,1,2,0,1,2;
  - rf_we continuous from cycle 2 through cycle 7.
- Requester 2 writes rd=0, data=32'h1234:
  - req_ready[2]=1 and rf_we stays 0;
  - x0_drop_cnt goes 0 -> 1.
- pause_req raised while requesters 0 and 2 are valid (rr_ptr=2):
  - no grant that cycle; DRAIN for one cycle, then paused=1;
  - no rf_we while paused;
  - drop pause_req: first grant goes to requester 2, then 0.
- rst asserted the cycle after a transfer to rd=7:
  - rf_we=0 the next cycle;
  - all outputs at reset values;
  - after release, normal grants resume from rr_ptr=0.
- With SIMPRISC_WB_FWD_EN defined and a transfer rd=9, data=32'hA5A5A5A5:
  - in the rf_we cycle, fwd_raddr=9 gives fwd_hit=1 and fwd_data=32'hA5A5A5A5;
  - fwd_raddr=0 gives fwd_hit=0.
